// File: rtl/pattern_pkg.sv
// Shared definitions for the serial pattern generator and its detectors:
// FSM state encoding, b/c line symbols and the default "bbcbc" sequence.
package pattern_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_GAP  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic B = 1'b0;
   localparam logic C = 1'b1;

   // "bbcbc" with the first symbol in bit 0
   localparam logic [4:0] BBCBC = {C, B, C, B, B};

endpackage

// File: rtl/bbcbc_pattern_gen.sv
// Serial pattern transmitter: sends PATTERN (LSB first) reps times with GAP idle cycles
// between repetitions; Moore outputs, first bit one cycle after start, done one cycle after last bit.
module bbcbc_pattern_gen
   import pattern_pkg::*;
#(
   parameter int                 PAT_LEN = 5,
   parameter logic [PAT_LEN-1:0] PATTERN = BBCBC,
   parameter int                 GAP     = 0,
   parameter int                 CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] reps,
   output logic             out,
   output logic             valid,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] sent_count
);

   localparam int IW = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
   localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(PAT_LEN - 1);
   localparam logic [GW-1:0] LAST_GAP = GW'(GAP - 1);

   state_t           state, state_n;
   logic [IW-1:0]    idx, idx_n;
   logic [GW-1:0]    gcnt, gcnt_n;
   logic [CNT_W-1:0] rem, rem_n;
   logic [CNT_W-1:0] cnt_n;
   logic             out_n, valid_n, busy_n, done_n;

   always_comb begin
      state_n = state;
      idx_n   = idx;
      gcnt_n  = gcnt;
      rem_n   = rem;
      cnt_n   = sent_count;

      case (state)
         S_IDLE: begin
            if (start) begin
               cnt_n   = '0;
               rem_n   = reps;
               idx_n   = '0;
               gcnt_n  = '0;
               state_n = (reps != '0) ? S_SEND : S_DONE;
            end
         end
         S_SEND: begin
            if (idx == LAST_IDX) begin
               cnt_n = sent_count + CNT_W'(1);
               rem_n = rem - CNT_W'(1);
               idx_n = '0;
               if (rem == CNT_W'(1)) begin
                  state_n = S_DONE;
               end else if (GAP != 0) begin
                  gcnt_n  = '0;
                  state_n = S_GAP;
               end
            end else begin
               idx_n = idx + IW'(1);
            end
         end
         S_GAP: begin
            if (gcnt == LAST_GAP) begin
               idx_n   = '0;
               state_n = S_SEND;
            end else begin
               gcnt_n = gcnt + GW'(1);
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they can be registered
      // and still line up with the state they describe.
      out_n   = C;
      valid_n = 1'b0;
      busy_n  = (state_n != S_IDLE);
      done_n  = (state_n == S_DONE);
      if (state_n == S_SEND) begin
         out_n   = PATTERN[idx_n];
         valid_n = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         idx        <= '0;
         gcnt       <= '0;
         rem        <= '0;
         sent_count <= '0;
         out        <= C;
         valid      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         gcnt       <= gcnt_n;
         rem        <= rem_n;
         sent_count <= cnt_n;
         out        <= out_n;
         valid      <= valid_n;
         busy       <= busy_n;
         done       <= done_n;
      end
   end

endmodule

// File: tb/tb_bbcbc_pattern_gen.sv
// Bench for bbcbc_pattern_gen: back-to-back and GAP=2 instances, scoreboard of expected
// bits and completion counts popped by a monitor, plus a behavioural bbcbc detector on the line.
module tb_bbcbc_pattern_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] reps = 8'd0;
   logic       sel = 1'b0;

   logic       start0, start2;
   logic       out0, valid0, busy0, done0;
   logic       out2, valid2, busy2, done2;
   logic [7:0] cnt0, cnt2;
   logic       s_out, s_valid, s_busy, s_done;
   logic [7:0] s_cnt;

   int tests = 0;
   int fails = 0;

   logic q_bits[$];
   logic [7:0] q_cnt[$];
   logic exp_seq [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   logic [3:0] det_sr = 4'hF;
   int         det_hits = 0;

   always #5 clk = ~clk;

   assign start0  = start & ~sel;
   assign start2  = start & sel;
   assign s_out   = sel ? out2   : out0;
   assign s_valid = sel ? valid2 : valid0;
   assign s_busy  = sel ? busy2  : busy0;
   assign s_done  = sel ? done2  : done0;
   assign s_cnt   = sel ? cnt2   : cnt0;

   bbcbc_pattern_gen #(.GAP(0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .reps(reps),
      .out(out0), .valid(valid0), .busy(busy0), .done(done0), .sent_count(cnt0)
   );

   bbcbc_pattern_gen #(.GAP(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .reps(reps),
      .out(out2), .valid(valid2), .busy(busy2), .done(done2), .sent_count(cnt2)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural bbcbc detector watching the line continuously (0,0,1,0,1 oldest first)
   always @(posedge clk) begin
      det_sr <= {det_sr[2:0], s_out};
      if ({det_sr, s_out} == 5'b00101) det_hits <= det_hits + 1;
   end

   // Monitor: every valid bit and every done pulse consumes a scoreboard entry
   always @(negedge clk) begin
      if (!rst) begin
         if (s_valid) begin
            if (q_bits.size() == 0) chk("unexpected_bit", 32'd1, 32'd0);
            else chk("bit", 32'(s_out), 32'(q_bits.pop_front()));
         end
         if (s_done) begin
            if (q_cnt.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else chk("done_sent_count", 32'(s_cnt), 32'(q_cnt.pop_front()));
         end
      end
   end

   task automatic burst(input int r, input int exp_valid, input int exp_gap,
                        input int exp_busy, input bit pulse);
      int vc, gc, bc, k, extra_done;
      for (int rr = 0; rr < r; rr++)
         for (int i = 0; i < 5; i++) q_bits.push_back(exp_seq[i]);
      q_cnt.push_back(8'(r));
      @(negedge clk);
      start = 1'b1;
      reps  = 8'(r);
      @(posedge clk); #1;
      start = 1'b0;
      reps  = 8'd7;
      chk("busy_rise", 32'(s_busy), 32'd1);
      chk("first_valid", 32'(s_valid), 32'(r != 0));
      vc = 0; gc = 0; bc = 0; k = 0;
      while (!s_done && k < 200) begin
         bc++;
         if (s_valid) vc++; else gc++;
         start = (pulse && s_valid && vc == 3);
         @(posedge clk); #1;
         k++;
      end
      start = 1'b0;
      if (k >= 200) chk("done_timeout", 32'd0, 32'd1);
      chk("busy_in_done", 32'(s_busy), 32'd1);
      chk("valid_cycles", 32'(vc), 32'(exp_valid));
      chk("gap_cycles", 32'(gc), 32'(exp_gap));
      chk("busy_cycles", 32'(bc + 1), 32'(exp_busy));
      extra_done = 0;
      @(posedge clk); #1;
      chk("busy_fall", 32'(s_busy), 32'd0);
      for (int i = 0; i < 3; i++) begin
         if (s_done || s_valid) extra_done++;
         @(posedge clk); #1;
      end
      chk("no_extra_activity", 32'(extra_done), 32'd0);
      chk("sent_count_hold", 32'(s_cnt), 32'(r));
   endtask

   initial begin
      int h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out0", 32'(out0), 32'd1);
      chk("rst_valid0", 32'(valid0), 32'd0);
      chk("rst_busy0", 32'(busy0), 32'd0);
      chk("rst_done0", 32'(done0), 32'd0);
      chk("rst_cnt0", 32'(cnt0), 32'd0);
      chk("rst_out2", 32'(out2), 32'd1);
      chk("rst_cnt2", 32'(cnt2), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      sel = 1'b0;
      burst(1, 5, 0, 6, 1'b0);

      h0 = det_hits;
      burst(3, 15, 0, 16, 1'b0);
      chk("detector_hits", 32'(det_hits - h0), 32'd3);

      sel = 1'b1;
      burst(2, 10, 2, 13, 1'b0);

      sel = 1'b0;
      burst(0, 0, 0, 1, 1'b0);

      burst(2, 10, 0, 11, 1'b1);

      // Asynchronous reset while bit 3 is on the line
      for (int i = 0; i < 10; i++) q_bits.push_back(exp_seq[i % 5]);
      @(negedge clk);
      start = 1'b1;
      reps  = 8'd2;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("pre_rst_valid", 32'(s_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_out", 32'(s_out), 32'd1);
      chk("arst_valid", 32'(s_valid), 32'd0);
      chk("arst_busy", 32'(s_busy), 32'd0);
      chk("arst_done", 32'(s_done), 32'd0);
      chk("arst_cnt", 32'(s_cnt), 32'd0);
      q_bits.delete();
      q_cnt.delete();
      @(negedge clk);
      rst = 1'b0;
      burst(1, 5, 0, 6, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      chk("bits_left", 32'(q_bits.size()), 32'd0);
      chk("dones_left", 32'(q_cnt.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
